hrmf_seq_ctrl: RTL and testbench

Sequencer for the HRMF radix-16 datapath (R4BFU, ROTATOR0, MTU4X4, R4BFU, ROTATOR1). It accepts a job of N frames of 4 beats each, with 4 complex samples per beat. It drives the ROTATOR0 and MTU4X4 selects in step with the data, zero-fills during drain, and generates ROTATOR1 twiddle ROM addresses plus output valid/last aligned to the MTU latency. The datapath has no clock enable, so this block owns all timing.

---
 rtl/hrmf_pkg.sv | 25 ++
 rtl/hrmf_tag_dly.sv | 31 +++
 rtl/hrmf_seq_ctrl.sv | 171 +++++++++++++++++
 tb/tb_hrmf_seq_ctrl.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/hrmf_pkg.sv
// Shared constants and types for the HRMF radix-16 sequencer.
package hrmf_pkg;

  localparam int unsigned FrwDef        = 6;
  localparam int unsigned LatDef        = 3;
  localparam int unsigned BeatsPerFrame = 4;

  localparam logic [1:0] StIdle   = 2'd0;
  localparam logic [1:0] StArm    = 2'd1;
  localparam logic [1:0] StStream = 2'd2;
  localparam logic [1:0] StDrain  = 2'd3;

  localparam logic [1:0] RotNone = 2'd0;
  localparam logic [1:0] RotW16  = 2'd1;
  localparam logic [1:0] RotW8   = 2'd2;
  localparam logic [1:0] RotBoth = 2'd3;

  typedef struct packed {
    logic              valid;
    logic              last;
    logic [FrwDef-1:0] frame;
    logic [1:0]        beat;
  } tag_t;

endpackage

// File: rtl/hrmf_tag_dly.sv
// Fixed-latency delay line for per-beat output tags, cleared synchronously.
module hrmf_tag_dly
  import hrmf_pkg::*;
#(
  parameter int unsigned Width = 10,
  parameter int unsigned Depth = LatDef
) (
  input  logic             CLK,
  input  logic             CLR,
  input  logic [Width-1:0] tag_head,
  output logic [Width-1:0] tag_tail
);

  logic [Width-1:0] stage_q [Depth];

  always_ff @(posedge CLK) begin
    if (CLR) begin
      for (int unsigned i = 0; i < Depth; i++) begin
        stage_q[i] <= '0;
      end
    end else begin
      stage_q[0] <= tag_head;
      for (int unsigned i = 1; i < Depth; i++) begin
        stage_q[i] <= stage_q[i-1];
      end
    end
  end

  assign tag_tail = stage_q[Depth-1];

endmodule

// File: rtl/hrmf_seq_ctrl.sv
// HRMF datapath sequencer: beat/frame counting, ROTATOR0/MTU4X4 selects, zero-fill and
// output tags delayed to match the MTU4X4 latency.
module hrmf_seq_ctrl
  import hrmf_pkg::*;
#(
  parameter int unsigned FRW = FrwDef,
  parameter int unsigned LAT = LatDef
) (
  input  logic           CLK,
  input  logic           RST,
  input  logic           START,
  input  logic [FRW-1:0] CFG_NFRAMES,
  input  logic [1:0]     CFG_ROT,
  input  logic           IN_VALID,
  output logic           IN_READY,
  output logic [1:0]     DP_SEL_ROTATOR0,
  output logic [1:0]     DP_SEL_MTU4X4,
  output logic           DP_ZERO,
  output logic [FRW+1:0] TF_ADDR,
  output logic           OUT_VALID,
  output logic           OUT_LAST,
  output logic           BUSY,
  output logic           ERR
);

  localparam int unsigned TagW = FRW + 4;
  localparam int unsigned DrnW = (LAT > 1) ? $clog2(LAT) : 1;

  logic [1:0]      state_q, state_d;
  logic [1:0]      beat_q, beat_d;
  logic [FRW-1:0]  frame_q, frame_d;
  logic [FRW-1:0]  nframes_q, nframes_d;
  logic [1:0]      rot_q, rot_d;
  logic            err_q, err_d;
  logic [DrnW-1:0] drain_q, drain_d;

  logic            beat_acc;
  logic            underrun;
  logic            frame_end;
  logic            job_end;
  logic [FRW+1:0]  head_addr;
  logic [TagW-1:0] tag_head, tag_tail;

  assign frame_end = (beat_q == 2'd3);
  assign job_end   = frame_end && (frame_q == nframes_q);

  always_comb begin
    state_d         = state_q;
    beat_d          = beat_q;
    frame_d         = frame_q;
    nframes_d       = nframes_q;
    rot_d           = rot_q;
    err_d           = err_q;
    drain_d         = drain_q;
    IN_READY        = 1'b0;
    DP_SEL_ROTATOR0 = RotNone;
    DP_SEL_MTU4X4   = 2'd0;
    DP_ZERO         = 1'b0;
    beat_acc        = 1'b0;
    underrun        = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (START) begin
          state_d   = StArm;
          nframes_d = CFG_NFRAMES;
          err_d     = 1'b0;
          frame_d   = '0;
          beat_d    = 2'd0;
          rot_d     = RotNone;
        end
      end

      StArm: begin
        IN_READY      = 1'b1;
        DP_SEL_MTU4X4 = beat_q;
        // Waiting cycles feed zeros; the accepting cycle is real beat 0 of frame 0.
        if (IN_VALID) begin
          beat_acc        = 1'b1;
          DP_SEL_ROTATOR0 = CFG_ROT;
          rot_d           = CFG_ROT;
          beat_d          = 2'd1;
          state_d         = StStream;
        end else begin
          DP_ZERO = 1'b1;
        end
      end

      StStream: begin
        IN_READY      = 1'b1;
        DP_SEL_MTU4X4 = beat_q;
        beat_acc      = 1'b1;
        beat_d        = beat_q + 2'd1;
        underrun      = ~IN_VALID;
        DP_ZERO       = underrun;
        if (underrun) begin
          err_d = 1'b1;
        end
        if (beat_q == 2'd0) begin
          DP_SEL_ROTATOR0 = CFG_ROT;
          rot_d           = CFG_ROT;
        end else begin
          DP_SEL_ROTATOR0 = rot_q;
        end
        if (frame_end) begin
          if (job_end) begin
            state_d = StDrain;
            drain_d = '0;
          end else begin
            frame_d = frame_q + FRW'(1);
          end
        end
      end

      StDrain: begin
        DP_ZERO       = 1'b1;
        DP_SEL_MTU4X4 = beat_q;
        beat_d        = beat_q + 2'd1;
        if (drain_q == DrnW'(LAT - 1)) begin
          state_d = StIdle;
          beat_d  = 2'd0;
        end else begin
          drain_d = drain_q + DrnW'(1);
        end
      end

      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q   <= StIdle;
      beat_q    <= 2'd0;
      frame_q   <= '0;
      nframes_q <= '0;
      rot_q     <= RotNone;
      err_q     <= 1'b0;
      drain_q   <= '0;
    end else begin
      state_q   <= state_d;
      beat_q    <= beat_d;
      frame_q   <= frame_d;
      nframes_q <= nframes_d;
      rot_q     <= rot_d;
      err_q     <= err_d;
      drain_q   <= drain_d;
    end
  end

  // Tag enters the delay line in the beat's own cycle so it exits LAT cycles later.
  assign head_addr = beat_acc ? {frame_q, beat_q} : '0;
  assign tag_head  = {beat_acc, beat_acc & job_end, head_addr};

  hrmf_tag_dly #(
    .Width (TagW),
    .Depth (LAT)
  ) u_tag_dly (
    .CLK      (CLK),
    .CLR      (RST),
    .tag_head (tag_head),
    .tag_tail (tag_tail)
  );

  assign OUT_VALID = tag_tail[TagW-1];
  assign OUT_LAST  = tag_tail[TagW-2];
  assign TF_ADDR   = OUT_VALID ? tag_tail[FRW+1:0] : '0;
  assign BUSY      = (state_q != StIdle);
  assign ERR       = err_q;

endmodule

// File: tb/tb_hrmf_seq_ctrl.sv
// Directed bench for hrmf_seq_ctrl with a scoreboard of expected output beats.
module tb_hrmf_seq_ctrl;

  localparam int unsigned FRW = 6;
  localparam int unsigned LAT = 3;

  logic           CLK;
  logic           RST;
  logic           START;
  logic [FRW-1:0] CFG_NFRAMES;
  logic [1:0]     CFG_ROT;
  logic           IN_VALID;
  logic           IN_READY;
  logic [1:0]     DP_SEL_ROTATOR0;
  logic [1:0]     DP_SEL_MTU4X4;
  logic           DP_ZERO;
  logic [FRW+1:0] TF_ADDR;
  logic           OUT_VALID;
  logic           OUT_LAST;
  logic           BUSY;
  logic           ERR;

  hrmf_seq_ctrl #(
    .FRW (FRW),
    .LAT (LAT)
  ) dut (
    .CLK             (CLK),
    .RST             (RST),
    .START           (START),
    .CFG_NFRAMES     (CFG_NFRAMES),
    .CFG_ROT         (CFG_ROT),
    .IN_VALID        (IN_VALID),
    .IN_READY        (IN_READY),
    .DP_SEL_ROTATOR0 (DP_SEL_ROTATOR0),
    .DP_SEL_MTU4X4   (DP_SEL_MTU4X4),
    .DP_ZERO         (DP_ZERO),
    .TF_ADDR         (TF_ADDR),
    .OUT_VALID       (OUT_VALID),
    .OUT_LAST        (OUT_LAST),
    .BUSY            (BUSY),
    .ERR             (ERR)
  );

  typedef struct {
    int addr;
    bit last;
    int cyc;
  } exp_t;

  exp_t sb[$];
  int   vectors     = 0;
  int   miscompares = 0;
  int   cyc_n       = 0;

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Settle inputs, then check the output stream against the scoreboard.
  task automatic settle();
    exp_t e;
    #2;
    if (OUT_VALID === 1'b1) begin
      if (sb.size() == 0) begin
        chk("spurious_out_valid", 32'(OUT_VALID), 0);
      end else begin
        e = sb.pop_front();
        chk("tf_addr", 32'(TF_ADDR), e.addr);
        chk("out_last", 32'(OUT_LAST), 32'(e.last));
        chk("out_latency", cyc_n - e.cyc, LAT);
      end
    end else begin
      chk("idle_out_last", 32'(OUT_LAST), 0);
      chk("idle_tf_addr", 32'(TF_ADDR), 0);
      if (sb.size() > 0 && sb[0].cyc + int'(LAT) <= cyc_n) begin
        chk("missing_out_valid", 32'(OUT_VALID), 1);
        void'(sb.pop_front());
      end
    end
  endtask

  task automatic adv();
    @(posedge CLK);
    cyc_n++;
    @(negedge CLK);
  endtask

  // One job; drop<0 means no underrun, chg is the beat index where CFG_ROT switches ra->rb.
  task automatic job(input int nf, input int arm_wait, input int drop, input int chg,
                     input logic [1:0] ra, input logic [1:0] rb, input bit noise);
    int         n;
    exp_t       e;
    logic [1:0] rexp;
    n           = 4 * (nf + 1);
    START       = 1'b1;
    CFG_NFRAMES = FRW'(nf);
    CFG_ROT     = ra;
    IN_VALID    = 1'b1;
    settle();
    chk("idle_busy", 32'(BUSY), 0);
    chk("idle_ready", 32'(IN_READY), 0);
    chk("idle_mtu", 32'(DP_SEL_MTU4X4), 0);
    chk("idle_rot", 32'(DP_SEL_ROTATOR0), 0);
    chk("idle_zero", 32'(DP_ZERO), 0);
    adv();
    START    = 1'b0;
    IN_VALID = 1'b0;
    for (int w = 0; w < arm_wait; w++) begin
      settle();
      chk("arm_ready", 32'(IN_READY), 1);
      chk("arm_mtu", 32'(DP_SEL_MTU4X4), 0);
      chk("arm_rot", 32'(DP_SEL_ROTATOR0), 0);
      chk("arm_zero", 32'(DP_ZERO), 1);
      chk("arm_busy", 32'(BUSY), 1);
      chk("arm_err", 32'(ERR), 0);
      adv();
    end
    for (int k = 0; k < n; k++) begin
      IN_VALID = (k != drop);
      CFG_ROT  = (k < chg) ? ra : rb;
      if (noise && k == 5) begin
        START       = 1'b1;
        CFG_NFRAMES = ~FRW'(nf);
      end else begin
        START       = 1'b0;
        CFG_NFRAMES = FRW'(nf);
      end
      rexp = ((k - (k % 4)) < chg) ? ra : rb;
      settle();
      chk("beat_ready", 32'(IN_READY), 1);
      chk("beat_mtu", 32'(DP_SEL_MTU4X4), k % 4);
      chk("beat_rot", 32'(DP_SEL_ROTATOR0), 32'(rexp));
      chk("beat_zero", 32'(DP_ZERO), 32'(k == drop));
      chk("beat_err", 32'(ERR), 32'(drop >= 0 && drop < k));
      chk("beat_busy", 32'(BUSY), 1);
      e.addr = k % (4 << FRW);
      e.last = (k == n - 1);
      e.cyc  = cyc_n;
      sb.push_back(e);
      adv();
    end
    IN_VALID    = 1'b0;
    CFG_NFRAMES = FRW'(nf);
    for (int d = 0; d < int'(LAT); d++) begin
      START = noise && (d == 0);
      settle();
      chk("drain_ready", 32'(IN_READY), 0);
      chk("drain_zero", 32'(DP_ZERO), 1);
      chk("drain_busy", 32'(BUSY), 1);
      chk("drain_mtu", 32'(DP_SEL_MTU4X4), (n + d) % 4);
      chk("drain_rot", 32'(DP_SEL_ROTATOR0), 0);
      chk("drain_err", 32'(ERR), 32'(drop >= 0));
      adv();
    end
    START = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    RST         = 1'b1;
    START       = 1'b0;
    CFG_NFRAMES = '0;
    CFG_ROT     = 2'd0;
    IN_VALID    = 1'b0;
    adv();
    settle();
    chk("rst_busy", 32'(BUSY), 0);
    chk("rst_ready", 32'(IN_READY), 0);
    chk("rst_err", 32'(ERR), 0);
    chk("rst_out_valid", 32'(OUT_VALID), 0);
    chk("rst_zero", 32'(DP_ZERO), 0);
    adv();
    RST = 1'b0;

    job(0, 0, -1, 99, 2'd3, 2'd3, 1'b0);   // single frame, both rotations
    job(2, 0, -1, 6, 2'd1, 2'd2, 1'b0);    // CFG_ROT changes mid-frame 1
    job(1, 5, -1, 99, 2'd2, 2'd2, 1'b1);   // long ARM wait, START noise
    job(0, 0, 2, 99, 2'd1, 2'd1, 1'b0);    // underrun at frame 0 beat 2

    settle();
    chk("err_sticky", 32'(ERR), 1);
    chk("err_idle_busy", 32'(BUSY), 0);
    adv();

    job(1, 1, -1, 99, 2'd1, 2'd1, 1'b0);   // START clears ERR
    job(0, 0, 1, 99, 2'd0, 2'd0, 1'b0);    // set ERR again

    RST = 1'b1;
    settle();
    chk("err_before_rst", 32'(ERR), 1);
    adv();
    RST = 1'b0;
    settle();
    chk("err_after_rst", 32'(ERR), 0);
    adv();

    // Reset in STREAM beat 1: in-flight tags must never emerge.
    START       = 1'b1;
    CFG_NFRAMES = FRW'(2);
    IN_VALID    = 1'b0;
    settle();
    adv();
    START    = 1'b0;
    IN_VALID = 1'b1;
    CFG_ROT  = 2'd3;
    settle();
    chk("pre_rst_mtu", 32'(DP_SEL_MTU4X4), 0);
    adv();
    RST = 1'b1;
    settle();
    chk("pre_rst_beat1", 32'(DP_SEL_MTU4X4), 1);
    adv();
    RST = 1'b0;
    settle();
    chk("mid_rst_busy", 32'(BUSY), 0);
    chk("mid_rst_ready", 32'(IN_READY), 0);
    chk("mid_rst_mtu", 32'(DP_SEL_MTU4X4), 0);
    chk("mid_rst_rot", 32'(DP_SEL_ROTATOR0), 0);
    chk("mid_rst_zero", 32'(DP_ZERO), 0);
    chk("mid_rst_err", 32'(ERR), 0);
    adv();
    for (int i = 0; i < 5; i++) begin
      settle();
      chk("post_rst_out_valid", 32'(OUT_VALID), 0);
      chk("post_rst_busy", 32'(BUSY), 0);
      adv();
    end
    IN_VALID = 1'b0;

    job(63, 0, -1, 99, 2'd1, 2'd1, 1'b0);  // largest legal job

    for (int i = 0; i < 4; i++) begin
      settle();
      adv();
    end
    chk("sb_empty", sb.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
